// File: rtl/instr_emitter.sv
// ---------------------------------------------------------------------------
// instr_emitter
//
// Purpose:
//   Expands high-level commands (load 8-bit immediate, register move, math
//   op, function call) into one to three 9-bit instruction words in the
//   9-bit CPU's ISA encoding. Words are emitted one per handshake on a
//   valid/ready output stream. Illegal commands emit no words and produce
//   a one-cycle cmd_err pulse instead.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  emitter idle and able to accept a command
//   cmd_type   in   0 LOADIMM, 1 MOVE, 2 MATH, 3 FUNC
//   cmd_dst    in   destination register code (MATH: bit 0 selects r/s)
//   cmd_src    in   source register / math code / function code
//   cmd_imm    in   8-bit immediate for LOADIMM
//   ins_valid  out  ins_word is valid
//   ins_ready  in   consumer accepts the current word
//   ins_word   out  {opcode[4:0], operand[3:0]}
//   ins_last   out  final word of the current command's expansion
//   cmd_err    out  one-cycle pulse: accepted command was illegal
//   word_cnt   out  count of handed-off words, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module instr_emitter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_type,
  input  logic [3:0]       cmd_dst,
  input  logic [3:0]       cmd_src,
  input  logic [7:0]       cmd_imm,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [8:0]       ins_word,
  output logic             ins_last,
  output logic             cmd_err,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    W0,
    W1,
    W2,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    CMD_LOADIMM = 2'd0,
    CMD_MOVE    = 2'd1,
    CMD_MATH    = 2'd2,
    CMD_FUNC    = 2'd3
  } cmd_t;

  localparam logic [3:0] REG_R = 4'd0;
  localparam logic [3:0] REG_S = 4'd1;

  localparam logic [4:0] OP_VALL = 5'b00000;
  localparam logic [4:0] OP_VALH = 5'b00001;
  localparam logic [3:0] OP_MTH  = 4'b1101;
  localparam logic [4:0] OP_FUNC = 5'b11111;

  state_t     state;
  state_t     state_next;

  cmd_t       lat_type;
  logic [3:0] lat_dst;
  logic [3:0] lat_src;
  logic [7:0] lat_imm;

  logic       accept;
  logic       cmd_legal;
  logic       handshake;

  logic [8:0] word0;
  logic [8:0] word1;
  logic [8:0] word2;
  logic [1:0] last_idx;

  assign accept    = (state == IDLE) && cmd_valid;
  assign handshake = ins_valid && ins_ready;

  // Only register moves into r/s and an immediate load into s are illegal;
  // r and s are the implicit operands of the load/math instructions.
  always_comb begin
    cmd_legal = 1'b1;
    case (cmd_t'(cmd_type))
      CMD_LOADIMM: cmd_legal = (cmd_dst != REG_S);
      CMD_MOVE:    cmd_legal = (cmd_dst != REG_R) && (cmd_dst != REG_S);
      default:     cmd_legal = 1'b1;
    endcase
  end

  // Command fields are captured once at acceptance so that later activity on
  // the command port cannot disturb an expansion already in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_type <= CMD_LOADIMM;
      lat_dst  <= 4'd0;
      lat_src  <= 4'd0;
      lat_imm  <= 8'd0;
    end else if (accept) begin
      lat_type <= cmd_t'(cmd_type);
      lat_dst  <= cmd_dst;
      lat_src  <= cmd_src;
      lat_imm  <= cmd_imm;
    end
  end

  // Expansion of the latched command into its word sequence. last_idx is
  // the index of the final word; a LOADIMM to a register other than r needs
  // a trailing move out of r, which is why r gets clobbered.
  always_comb begin
    word0    = 9'd0;
    word1    = 9'd0;
    word2    = 9'd0;
    last_idx = 2'd0;
    case (lat_type)
      CMD_LOADIMM: begin
        word0    = {OP_VALL, lat_imm[3:0]};
        word1    = {OP_VALH, lat_imm[7:4]};
        word2    = {1'b0, lat_dst, REG_R};
        last_idx = (lat_dst == REG_R) ? 2'd1 : 2'd2;
      end
      CMD_MOVE: begin
        word0 = {1'b0, lat_dst, lat_src};
      end
      CMD_MATH: begin
        word0 = {OP_MTH, lat_dst[0], lat_src};
      end
      CMD_FUNC: begin
        word0 = {OP_FUNC, lat_src};
      end
      default: begin
        word0 = 9'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a word state only advances on a consumer handshake,
  // which is what keeps ins_word/ins_last stable during backpressure.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = cmd_legal ? W0 : ERR;
        end
      end
      W0: begin
        if (ins_ready) begin
          state_next = (last_idx == 2'd0) ? IDLE : W1;
        end
      end
      W1: begin
        if (ins_ready) begin
          state_next = (last_idx == 2'd1) ? IDLE : W2;
        end
      end
      W2: begin
        if (ins_ready) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode purely from registered state and latched fields, so no
  // combinational path exists from the input ports to any output.
  always_comb begin
    cmd_ready = 1'b0;
    ins_valid = 1'b0;
    ins_word  = 9'd0;
    ins_last  = 1'b0;
    cmd_err   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      W0: begin
        ins_valid = 1'b1;
        ins_word  = word0;
        ins_last  = (last_idx == 2'd0);
      end
      W1: begin
        ins_valid = 1'b1;
        ins_word  = word1;
        ins_last  = (last_idx == 2'd1);
      end
      W2: begin
        ins_valid = 1'b1;
        ins_word  = word2;
        ins_last  = 1'b1;
      end
      ERR: begin
        cmd_err = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  // Handed-off word counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
    end else if (handshake) begin
      word_cnt <= word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
